// File: rtl/mac_pipeline_acc.sv
// Purpose: multi-lane multiply-accumulate; each lane does W*I+O (pass) or a running sum of W*I (accumulate).
// Latency: MUL_STAGES+1 cycles from an accepted beat to out_valid; full rate, one beat per cycle.
// Backpressure: none; every in_valid beat is accepted, and bubbles (in_valid=0) pass through inert.
module mac_pipeline_acc #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 64,
    parameter int OUT_W      = 32,
    parameter int LANES      = 4,
    parameter int MUL_STAGES = 5,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      acc_mode,
    input  logic                      acc_first,
    input  logic                      acc_last,
    input  logic [LANES*DATA_W-1:0]   w_data,
    input  logic [LANES*DATA_W-1:0]   i_data,
    input  logic [LANES*DATA_W-1:0]   o_data,
    output logic                      out_valid,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic [LANES-1:0]          out_sat
);
    localparam int   PW   = 2 * DATA_W;
    localparam int   L    = MUL_STAGES - 1;
    localparam logic SGN  = (SIGNED != 0);
    localparam logic SAT  = (SATURATE != 0);
    localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SMAX = ~SMIN;

    // Extending both operands to the full product width makes one multiplier serve both signednesses.
    function automatic logic [PW-1:0] mul_ext(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        if (SGN) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
        end
        return ax * bx;
    endfunction

    function automatic logic [ACC_W-1:0] ext_p(input logic [PW-1:0] p);
        if (SGN) return ACC_W'($signed(p));
        else     return ACC_W'(p);
    endfunction

    function automatic logic [ACC_W-1:0] ext_o(input logic [DATA_W-1:0] o);
        if (SGN) return ACC_W'($signed(o));
        else     return ACC_W'(o);
    endfunction

    // Returns {clamped_flag, result}; overflow means the bits above the output field are not pure extension.
    function automatic logic [OUT_W:0] conv(input logic [ACC_W-1:0] v);
        logic [OUT_W-1:0]        lo;
        logic signed [ACC_W-1:0] hi;
        logic                    ovf;
        lo  = v[OUT_W-1:0];
        ovf = 1'b0;
        hi  = '0;
        if (SAT) begin
            if (SGN) begin
                hi  = $signed(v) >>> (OUT_W - 1);
                ovf = (hi != '0) && (hi != '1);
                if (ovf) lo = v[ACC_W-1] ? SMIN : SMAX;
            end else begin
                ovf = (v >> OUT_W) != '0;
                if (ovf) lo = '1;
            end
        end
        return {ovf, lo};
    endfunction

    logic [LANES*PW-1:0]     prod_in;
    logic [MUL_STAGES-1:0]   vld_p, mode_p, first_p, last_p;
    logic [LANES*PW-1:0]     prod_p [MUL_STAGES];
    logic [LANES*DATA_W-1:0] o_p    [MUL_STAGES];
    logic [ACC_W-1:0]        acc_q    [LANES];
    logic [ACC_W-1:0]        prod_x   [LANES];
    logic [ACC_W-1:0]        acc_sum  [LANES];
    logic [ACC_W-1:0]        pass_sum [LANES];
    logic [OUT_W:0]          res_cv   [LANES];
    logic                    emit, acc_upd;

    // Per-lane product feeding the first multiplier register.
    always_comb begin
        prod_in = '0;
        for (int k = 0; k < LANES; k++) begin
            prod_in[k*PW +: PW] = mul_ext(w_data[k*DATA_W +: DATA_W], i_data[k*DATA_W +: DATA_W]);
        end
    end

    // Multiplier pipeline; valid and sideband bits ride alongside the product and addend.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p   <= '0;
            mode_p  <= '0;
            first_p <= '0;
            last_p  <= '0;
            for (int s = 0; s < MUL_STAGES; s++) begin
                prod_p[s] <= '0;
                o_p[s]    <= '0;
            end
        end else begin
            vld_p[0]   <= in_valid;
            mode_p[0]  <= acc_mode;
            first_p[0] <= acc_first;
            last_p[0]  <= acc_last;
            prod_p[0]  <= prod_in;
            o_p[0]     <= o_data;
            for (int s = 1; s < MUL_STAGES; s++) begin
                vld_p[s]   <= vld_p[s-1];
                mode_p[s]  <= mode_p[s-1];
                first_p[s] <= first_p[s-1];
                last_p[s]  <= last_p[s-1];
                prod_p[s]  <= prod_p[s-1];
                o_p[s]     <= o_p[s-1];
            end
        end
    end

    // Add stage arithmetic: accumulator feedback and pass-mode sum, then output conversion.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_x[k]   = ext_p(prod_p[L][k*PW +: PW]);
            acc_sum[k]  = (first_p[L] ? '0 : acc_q[k]) + prod_x[k];
            pass_sum[k] = prod_x[k] + ext_o(o_p[L][k*DATA_W +: DATA_W]);
            res_cv[k]   = conv(mode_p[L] ? acc_sum[k] : pass_sum[k]);
        end
    end

    assign emit    = vld_p[L] & (~mode_p[L] | last_p[L]);
    assign acc_upd = vld_p[L] & mode_p[L];

    // Accumulators move only on valid accumulate-mode beats, so bubbles and pass beats leave them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
        end else if (acc_upd) begin
            for (int k = 0; k < LANES; k++) acc_q[k] <= acc_sum[k];
        end
    end

    // Output register; data and flags hold between emitted results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                for (int k = 0; k < LANES; k++) begin
                    out_data[k*OUT_W +: OUT_W] <= res_cv[k][OUT_W-1:0];
                    out_sat[k]                 <= res_cv[k][OUT_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_pipeline_acc.sv
// Purpose: self-checking bench for mac_pipeline_acc across three arithmetic configurations.
// Latency: expectations are due MUL_STAGES+1 cycles after each driven beat.
// Backpressure: not applicable; the DUT always accepts beats.
module tb_mac_pipeline_acc;
    localparam int DW  = 32;
    localparam int LN  = 4;
    localparam int MS  = 5;
    localparam int LAT = MS + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, acc_mode, acc_first, acc_last;
    logic [LN*DW-1:0] w_data, i_data, o_data;
    logic ov0, ov1, ov2;
    logic [127:0] od0, od1;
    logic [255:0] od2;
    logic [3:0] os0, os1, os2;

    // inst 0: signed, saturating, 32-bit out; inst 1: signed, truncating; inst 2: unsigned, 64-bit out
    mac_pipeline_acc #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .LANES(4), .MUL_STAGES(5), .SIGNED(1), .SATURATE(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .acc_mode(acc_mode), .acc_first(acc_first), .acc_last(acc_last),
        .w_data(w_data), .i_data(i_data), .o_data(o_data), .out_valid(ov0), .out_data(od0), .out_sat(os0));
    mac_pipeline_acc #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .LANES(4), .MUL_STAGES(5), .SIGNED(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .acc_mode(acc_mode), .acc_first(acc_first), .acc_last(acc_last),
        .w_data(w_data), .i_data(i_data), .o_data(o_data), .out_valid(ov1), .out_data(od1), .out_sat(os1));
    mac_pipeline_acc #(.DATA_W(32), .ACC_W(64), .OUT_W(64), .LANES(4), .MUL_STAGES(5), .SIGNED(0), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .acc_mode(acc_mode), .acc_first(acc_first), .acc_last(acc_last),
        .w_data(w_data), .i_data(i_data), .o_data(o_data), .out_valid(ov2), .out_data(od2), .out_sat(os2));

    typedef struct { int due; int inst; logic [255:0] data; logic [3:0] sat; } exp_t;
    typedef struct { int due; int inst; logic [63:0] val; logic sat; } lit_t;
    exp_t exp_q[$];
    lit_t lit_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    logic [63:0] macc [3][4];

    logic         av [3];
    logic [255:0] ad [3];
    logic [3:0]   as_ [3];

    always_comb begin
        av[0] = ov0; av[1] = ov1; av[2] = ov2;
        ad[0] = {128'b0, od0}; ad[1] = {128'b0, od1}; ad[2] = od2;
        as_[0] = os0; as_[1] = os1; as_[2] = os2;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit cfg_sgn(int n); return n != 2; endfunction
    function automatic bit cfg_sat(int n); return n == 0; endfunction
    function automatic int cfg_ow(int n);  return (n == 2) ? 64 : 32; endfunction

    function automatic longint opnd(bit s, logic [31:0] x);
        if (s) return longint'($signed(x));
        return longint'({32'b0, x});
    endfunction

    // Reference result conversion from plain integer ranges.
    function automatic void conv(int n, logic [63:0] v, output logic [63:0] r, output logic f);
        int     ow;
        longint sv;
        longint lim;
        ow = cfg_ow(n);
        sv = v;
        r  = v;
        f  = 1'b0;
        if (cfg_sat(n) && ow < 64) begin
            if (cfg_sgn(n)) begin
                lim = longint'(1) <<< (ow - 1);
                if (sv > lim - 1) begin r = lim - 1; f = 1'b1; end
                else if (sv < -lim) begin r = -lim; f = 1'b1; end
            end else if (v > (64'd1 << ow) - 1) begin
                r = (64'd1 << ow) - 1; f = 1'b1;
            end
        end
        if (ow < 64) r = r & ((64'd1 << ow) - 1);
    endfunction

    task automatic model_beat();
        logic [255:0] d;
        logic [3:0]   s;
        logic [63:0]  p, v, r;
        logic         f;
        exp_t         e;
        for (int n = 0; n < 3; n++) begin
            d = '0;
            s = '0;
            for (int k = 0; k < LN; k++) begin
                p = opnd(cfg_sgn(n), w_data[k*DW +: DW]) * opnd(cfg_sgn(n), i_data[k*DW +: DW]);
                if (acc_mode) begin
                    if (acc_first) macc[n][k] = '0;
                    macc[n][k] = macc[n][k] + p;
                    v = macc[n][k];
                end else begin
                    v = p + opnd(cfg_sgn(n), o_data[k*DW +: DW]);
                end
                conv(n, v, r, f);
                d = d | (256'(r) << (k * cfg_ow(n)));
                s[k] = f;
            end
            if (!acc_mode || acc_last) begin
                e.due = cyc + LAT; e.inst = n; e.data = d; e.sat = s;
                exp_q.push_back(e);
            end
        end
    endtask

    // Reset drops every result not yet visible and clears the model accumulators.
    task automatic model_reset();
        for (int n = 0; n < 3; n++) for (int k = 0; k < LN; k++) macc[n][k] = '0;
        for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].due > cyc) exp_q.delete(j);
        for (int j = lit_q.size() - 1; j >= 0; j--) if (lit_q[j].due > cyc) lit_q.delete(j);
    endtask

    task automatic step(input bit r, input bit v, input bit m, input bit f, input bit l,
                        input logic [31:0] w0, input logic [31:0] i0, input logic [31:0] o0);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; acc_mode = m; acc_first = f; acc_last = l;
        for (int k = 0; k < LN; k++) begin
            w_data[k*DW +: DW] = w0 + 32'(k);
            i_data[k*DW +: DW] = i0 - 32'(k);
            o_data[k*DW +: DW] = o0 ^ (32'(k) * 32'h1111);
        end
        if (r) model_reset();
        else if (v) model_beat();
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic bubble();
        step(0, 0, 1, 1, 1, $urandom, $urandom, $urandom);
    endtask

    task automatic lit(int inst, logic [63:0] val, logic sat);
        lit_t e;
        e.due = cyc + LAT; e.inst = inst; e.val = val; e.sat = sat;
        lit_q.push_back(e);
    endtask

    // Every cycle: out_valid against the model for all instances, payload when valid, plus pinned literals.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < 3; n++) begin
                bit   ev;
                exp_t e;
                ev = 1'b0;
                e  = '{0, 0, '0, '0};
                foreach (exp_q[j]) if (exp_q[j].due == cyc && exp_q[j].inst == n) begin ev = 1'b1; e = exp_q[j]; end
                checks++;
                if (av[n] !== ev) begin
                    failures++;
                    $display("FAIL valid inst=%0d cyc=%0d got=%b want=%b", n, cyc, av[n], ev);
                end else if (ev) begin
                    checks++;
                    if (ad[n] !== e.data || as_[n] !== e.sat) begin
                        failures++;
                        $display("FAIL data inst=%0d cyc=%0d got=%h/%b want=%h/%b", n, cyc, ad[n], as_[n], e.data, e.sat);
                    end
                end
            end
            foreach (lit_q[j]) if (lit_q[j].due == cyc) begin
                logic [63:0] lane0;
                int          n;
                n = lit_q[j].inst;
                lane0 = (cfg_ow(n) == 64) ? ad[n][63:0] : {32'b0, ad[n][31:0]};
                checks++;
                if (av[n] !== 1'b1 || lane0 !== lit_q[j].val || as_[n][0] !== lit_q[j].sat) begin
                    failures++;
                    $display("FAIL literal inst=%0d cyc=%0d got v=%b %h sat=%b want %h sat=%b",
                             n, cyc, av[n], lane0, as_[n][0], lit_q[j].val, lit_q[j].sat);
                end
            end
            for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].due <= cyc) exp_q.delete(j);
            for (int j = lit_q.size() - 1; j >= 0; j--) if (lit_q[j].due <= cyc) lit_q.delete(j);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; acc_mode = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
        w_data = '0; i_data = '0; o_data = '0;
        for (int n = 0; n < 3; n++) for (int k = 0; k < LN; k++) macc[n][k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0 || od0 !== '0 || os0 !== '0) begin
            failures++;
            $display("FAIL reset_inst0 got v=%b d=%h s=%b want 0/0/0", ov0, od0, os0);
        end
        checks++;
        if (ov2 !== 1'b0 || od2 !== '0 || os2 !== '0) begin
            failures++;
            $display("FAIL reset_inst2 got v=%b d=%h s=%b want 0/0/0", ov2, od2, os2);
        end
        chk_en = 1'b1;
        idle(2);

        // pass mode: 3*4+5
        step(0, 1, 0, 0, 0, 32'd3, 32'd4, 32'd5);
        lit(0, 64'd17, 1'b0);
        idle(8);

        // accumulate burst: (1+2+3+4)*10
        for (int j = 1; j <= 4; j++) begin
            step(0, 1, 1, j == 1, j == 4, 32'(j), 32'd10, 32'd0);
            if (j == 4) lit(0, 64'd100, 1'b0);
        end
        idle(8);

        // signed overflow: clamped vs truncated
        step(0, 1, 0, 0, 0, 32'h7FFF_FFFF, 32'd2, 32'd0);
        lit(0, 64'h7FFF_FFFF, 1'b1);
        lit(1, 64'hFFFF_FFFE, 1'b0);
        idle(8);

        // burst with bubbles and a pass beat in the middle: 30+6+1, pass 7*8+9
        step(0, 1, 1, 1, 0, 32'd5, 32'd6, 32'd0);
        bubble();
        step(0, 1, 0, 0, 0, 32'd7, 32'd8, 32'd9);
        lit(0, 64'd65, 1'b0);
        bubble();
        step(0, 1, 1, 0, 0, 32'd2, 32'd3, 32'd0);
        step(0, 1, 1, 0, 1, 32'd1, 32'd1, 32'd0);
        lit(0, 64'd37, 1'b0);
        idle(8);

        // reset while beat 2 (a last beat) is in flight, then single-beat burst and a firstless add
        step(0, 1, 1, 1, 0, 32'd5, 32'd5, 32'd0);
        step(0, 1, 1, 0, 0, 32'd6, 32'd6, 32'd0);
        step(0, 1, 1, 0, 1, 32'd7, 32'd7, 32'd0);
        step(1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        step(0, 1, 1, 1, 1, 32'd2, 32'd2, 32'd0);
        lit(0, 64'd4, 1'b0);
        idle(2);
        step(0, 1, 1, 0, 1, 32'd3, 32'd3, 32'd0);
        lit(0, 64'd13, 1'b0);
        idle(8);

        // unsigned full-range product
        step(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        lit(2, 64'hFFFF_FFFE_0000_0001, 1'b0);
        lit(0, 64'd1, 1'b0);
        idle(8);

        // full-rate mixed stream, back-to-back
        for (int j = 0; j < 6; j++)
            step(0, 1, 0, 0, 0, 32'(j) * 32'h0123_4567, 32'h89AB_CDEF ^ 32'(j), 32'(j) * 32'h1000_0001);
        for (int j = 0; j < 5; j++)
            step(0, 1, 1, j == 0, j == 4, 32'h4000_0000 + 32'(j), 32'h7000_0000 - 32'(j), 32'd0);
        step(0, 1, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'd0);
        idle(10);

        checks++;
        if (exp_q.size() != 0 || lit_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", exp_q.size(), lit_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_pipeline_acc.md
Name: mac_pipeline_acc

Overview:
- Multi-lane, parametrised multiply-accumulate pipeline; successor to the single-lane fixed-width MAC.
- Each lane computes W*I, then either adds a per-lane external operand (pass mode) or accumulates internally over a burst (accumulate mode), with optional saturation.
- Multiplier stages are in-RTL registers, so the block is self-contained.
- Valid tracking replaces the separate NOP shift pipeline.
- Sits in the PE array between operand fetch and output write-back.

Parameters:
- DATA_W, 32, operand width (W, I, O per lane)
- ACC_W, 64, internal accumulator width (must be >= 2*DATA_W)
- OUT_W, 32, output width per lane (<= ACC_W)
- LANES, 4, number of parallel MAC lanes
- MUL_STAGES, 5, register stages in the multiplier path (>= 1)
- SIGNED, 1, 1 = two's-complement arithmetic, 0 = unsigned
- SATURATE, 1, 1 = clamp result to OUT_W range, 0 = truncate to low OUT_W bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid; low = NOP bubble
- acc_mode  in  1  0 = pass mode (W*I+O); 1 = accumulate mode
- acc_first  in  1  accumulate mode: beat starts a new accumulation (acc seeded from 0)
- acc_last  in  1  accumulate mode: beat ends the accumulation; result emitted
- w_data  in  LANES*DATA_W  weights; lane k at [k*DATA_W +: DATA_W]
- i_data  in  LANES*DATA_W  inputs, same packing
- o_data  in  LANES*DATA_W  pass-mode addend, same packing; sign-extended (SIGNED=1) or zero-extended to ACC_W
- out_valid  out  1  out_data valid this cycle
- out_data  out  LANES*OUT_W  results, lane k at [k*OUT_W +: OUT_W]
- out_sat  out  LANES  per-lane flag: result was clamped (SATURATE=1 only, else 0)

Behaviour:
- Reset: out_valid=0, out_data=0, out_sat=0; all pipeline valid bits, sideband bits (mode/first/last) and accumulators cleared.
- Reset mid-operation discards in-flight beats and partial accumulations; no out_valid for them after reset deasserts.
- Sampling: all inputs sampled when in_valid=1. Sideband bits and o_data travel alongside the product through MUL_STAGES delay registers.
- Multiplier: product is 2*DATA_W bits, signedness per SIGNED, available after MUL_STAGES cycles, then extended to ACC_W.
- Add stage: one registered stage; total latency from input beat to out_valid is MUL_STAGES+1 cycles.
- Pass mode: sum = ext(product) + ext(o_data). out_valid=1 for every valid beat.
- Accumulate mode: acc = (acc_first ? 0 : acc) + ext(product), updated on each valid beat at the add stage.
  - out_valid=1 only on the acc_last beat; the emitted value includes that beat.
  - acc_first and acc_last on the same beat give a single-product result.
  - Accumulator is ACC_W and wraps modulo 2^ACC_W internally.
- Feedback path: back-to-back valid beats at full rate are supported with no bubbles; the accumulator forward path is a single cycle.
- Bubbles: in_valid=0 beats neither change the accumulator nor raise out_valid. A burst may contain bubbles.
- Mode switch: a pass-mode beat mid-burst does not disturb the accumulator. The accumulator is only cleared by acc_first or rst.
- Accumulate beat without prior acc_first: adds to the current accumulator value (0 after reset).
- Output conversion, SATURATE=1:
  - SIGNED=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SIGNED=0: clamp to [0, 2^OUT_W-1].
  - out_sat[k]=1 when clamped.
- Output conversion, SATURATE=0: low OUT_W bits; out_sat=0.
- Hold: out_data and out_sat hold their last values while out_valid=0.
- Lanes: lanes are independent arithmetically and share valid/mode/first/last.

Test Plan:
- Reset, then pass mode, LANES=4, MUL_STAGES=5: lane0 w=3, i=4, o=5 at cycle 0 -> out_valid at cycle 6, lane0 out=17, out_sat=0.
- Accumulate burst, 4 consecutive beats (first on beat 0, last on beat 3), lane0 w=1..4, i=10 -> single out_valid 6 cycles after beat 3, lane0 out=100; no out_valid on beats 0-2.
- Signed saturation, SIGNED=1, SATURATE=1, OUT_W=32: w=0x7FFFFFFF, i=2, o=0 -> out=0x7FFFFFFF, out_sat[0]=1. Repeat with SATURATE=0 -> out=0xFFFFFFFE, out_sat=0.
- Bubbles and interleave: burst with in_valid=0 gaps, plus a pass-mode beat mid-burst -> accumulated result unaffected; the pass beat emits its own W*I+O at latency 6.
- Reset mid-burst: assert rst for 1 cycle after beat 2 of a burst, then a new burst w=2, i=2 with first+last on the same beat -> only one out_valid, out=4; no stale outputs.
- Unsigned mode, SIGNED=0: w=0xFFFFFFFF, i=0xFFFFFFFF, OUT_W=64, SATURATE=0 -> out=0xFFFFFFFE00000001.
